// File: rtl/npu_job_sequencer.sv
// npu_job_sequencer: host-side initiator for the atom NPU core.
// Unpacks operand bytes {weight, input}, issues one start pulse per pair,
// waits for the core's done strobe, and queues results in a small FIFO that
// drains through a valid/ready stream. A timeout in WAIT sets a sticky error.
// Optional build macro NPU_SEQ_ACCUM_EN: accumulate results (saturating at 15)
// across a vector of VEC_LEN elements and push only the final sum.
//
// Handshakes: a beat transfers on a rising clock edge when valid and ready are
// both high; valid never waits on ready, and ready is registered so it has no
// combinational path from valid (in_valid/in_ready and res_valid/res_ready).
module npu_job_sequencer #(
  parameter int VEC_LEN   = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       npu_start,
  output logic [3:0] npu_input,
  output logic [3:0] npu_weight,
  input  logic [3:0] npu_result,
  input  logic       npu_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       busy,
  output logic [3:0] elem_idx,
  input  logic       clr_err,
  output logic       err_timeout,
  output logic [1:0] state_dbg
);

  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [3:0]    LAST_IDX = 4'(VEC_LEN - 1);
  localparam logic [7:0]    TMAX     = 8'(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(RES_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       in_ready_q, in_ready_d;
  logic [3:0]                 npu_input_q, npu_input_d;
  logic [3:0]                 npu_weight_q, npu_weight_d;
  logic [3:0]                 elem_q, elem_d;
  logic [7:0]                 tcnt_q, tcnt_d;
  logic                       err_q, err_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [3:0]                 res_data_q, res_data_d;
  logic [RES_DEPTH-1:0][3:0]  mem_q, mem_d;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic [3:0]                 push_data;
`ifdef NPU_SEQ_ACCUM_EN
  logic [3:0]                 accum_q, accum_d;
  logic [4:0]                 acc_sum;
  logic [3:0]                 acc_sat;
`endif

  // Job FSM next state: accept an operand, pulse start, wait for done or timeout.
  always_comb begin
    state_d      = state_q;
    npu_input_d  = npu_input_q;
    npu_weight_d = npu_weight_q;
    elem_d       = elem_q;
    tcnt_d       = tcnt_q;
    err_d        = err_q && !clr_err;
    push         = 1'b0;
    push_data    = npu_result;
    accept       = (state_q == S_IDLE) && in_valid && in_ready_q;
`ifdef NPU_SEQ_ACCUM_EN
    accum_d      = accum_q;
    acc_sum      = {1'b0, accum_q} + {1'b0, npu_result};
    acc_sat      = acc_sum[4] ? 4'hF : acc_sum[3:0];
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          npu_input_d  = in_data[3:0];
          npu_weight_d = in_data[7:4];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tcnt_d  = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (npu_done) begin
          state_d = S_IDLE;
`ifdef NPU_SEQ_ACCUM_EN
          if (elem_q == LAST_IDX) begin
            push      = 1'b1;
            push_data = acc_sat;
            accum_d   = 4'd0;
            elem_d    = 4'd0;
          end else begin
            accum_d = acc_sat;
            elem_d  = elem_q + 4'd1;
          end
`else
          push   = 1'b1;
          elem_d = (elem_q == LAST_IDX) ? 4'd0 : elem_q + 4'd1;
`endif
        end else if (tcnt_q == TMAX) begin
          // Set wins over a simultaneous clr_err.
          err_d   = 1'b1;
          state_d = S_IDLE;
`ifdef NPU_SEQ_ACCUM_EN
          accum_d = 4'd0;
          elem_d  = 4'd0;
`endif
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result FIFO bookkeeping; res_data is a registered copy of the next head.
  always_comb begin
    pop      = (count_q != '0) && res_ready;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      res_data_d = 4'd0;
    end else if ((count_q == '0) || (pop && (count_q == CW'(1)))) begin
      // The freshly pushed entry becomes the only entry.
      res_data_d = push_data;
    end else begin
      res_data_d = mem_q[rd_ptr_d];
    end
    // A slot is reserved before accepting, so WAIT can always push.
    in_ready_d = (state_d == S_IDLE) && (count_d != FULL_CNT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      npu_input_q  <= 4'd0;
      npu_weight_q <= 4'd0;
      elem_q       <= 4'd0;
      tcnt_q       <= 8'd0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res_data_q   <= 4'd0;
      mem_q        <= '0;
`ifdef NPU_SEQ_ACCUM_EN
      accum_q      <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      npu_input_q  <= npu_input_d;
      npu_weight_q <= npu_weight_d;
      elem_q       <= elem_d;
      tcnt_q       <= tcnt_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_data_q   <= res_data_d;
      mem_q        <= mem_d;
`ifdef NPU_SEQ_ACCUM_EN
      accum_q      <= accum_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign npu_start   = (state_q == S_ISSUE);
  assign npu_input   = npu_input_q;
  assign npu_weight  = npu_weight_q;
  assign res_valid   = (count_q != '0);
  assign res_data    = res_data_q;
  assign busy        = (state_q != S_IDLE);
  assign elem_idx    = elem_q;
  assign err_timeout = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_npu_job_sequencer.sv
// Testbench for npu_job_sequencer: directed steps followed by a randomized
// phase scored against a result queue built from the job-level rules.
module tb_npu_job_sequencer;

  localparam int VEC_LEN   = 4;
  localparam int RES_DEPTH = 4;
  localparam int TIMEOUT   = 10;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       npu_start;
  logic [3:0] npu_input;
  logic [3:0] npu_weight;
  logic [3:0] npu_result = 4'd0;
  logic       npu_done   = 1'b0;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       busy;
  logic [3:0] elem_idx;
  logic       clr_err;
  logic       err_timeout;
  logic [1:0] state_dbg;

  int         errors = 0;
  int         checks = 0;
  int         core_lat = 1;     // 0: never respond, 255: random 1..4
  logic [3:0] exp_q[$];
  int         m_elem;
`ifdef NPU_SEQ_ACCUM_EN
  int         m_acc;
`endif

  npu_job_sequencer #(
    .VEC_LEN(VEC_LEN), .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .npu_start(npu_start), .npu_input(npu_input), .npu_weight(npu_weight),
    .npu_result(npu_result), .npu_done(npu_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .elem_idx(elem_idx),
    .clr_err(clr_err), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  // Core model: result = input + weight - 1 (mod 16), after core_lat cycles.
  function automatic logic [3:0] core_fn(input logic [3:0] a, input logic [3:0] b);
    return a + b - 4'd1;
  endfunction

  always begin : core_model
    int lat;
    logic [3:0] hold;
    @(posedge clk); #1;
    if (npu_start && !rst) begin
      lat  = (core_lat == 255) ? int'($urandom_range(1, 4)) : core_lat;
      hold = core_fn(npu_input, npu_weight);
      if (lat != 0) begin
        repeat (lat) @(posedge clk);
        #1;
        npu_result = hold;
        npu_done   = 1'b1;
        @(posedge clk); #1;
        npu_done   = 1'b0;
        npu_result = 4'd0;
      end
    end
  end

  // Scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_in_ready"}, in_ready, 0);
    chk({p, "_npu_start"}, npu_start, 0);
    chk({p, "_npu_input"}, npu_input, 0);
    chk({p, "_npu_weight"}, npu_weight, 0);
    chk({p, "_res_valid"}, res_valid, 0);
    chk({p, "_res_data"}, res_data, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_elem_idx"}, elem_idx, 0);
    chk({p, "_err_timeout"}, err_timeout, 0);
  endtask

  // Job-level reference: one result per operand, or one saturated sum per vector.
  task automatic model_accept(input logic [7:0] d);
    logic [3:0] r;
    r = core_fn(d[3:0], d[7:4]);
`ifdef NPU_SEQ_ACCUM_EN
    m_acc = (m_acc + int'(r) > 15) ? 15 : m_acc + int'(r);
    m_elem++;
    if (m_elem == VEC_LEN) begin
      exp_q.push_back(4'(m_acc));
      m_acc  = 0;
      m_elem = 0;
    end
`else
    exp_q.push_back(r);
    m_elem = (m_elem + 1) % VEC_LEN;
`endif
  endtask

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    in_valid = 1'b1; in_data = d; n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    chk("wait_idle", busy, 0);
  endtask

  task automatic drain_all();
    int n;
    res_ready = 1'b1;
    while (exp_q.size() != 0) begin
      n = 0;
      while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("drain_valid", res_valid, 1);
      if (!res_valid) begin exp_q.delete(); break; end
      chk("drain_data", res_data, exp_q.pop_front());
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    chk("drain_empty", res_valid, 0);
  endtask

  task automatic step(output logic acc);
    logic pop;
    acc = in_valid && in_ready;
    pop = res_valid && res_ready;
    if (pop) begin
      chk("rnd_pop_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rnd_data", res_data, exp_q.pop_front());
    end
    @(posedge clk); #1;
    if (acc) model_accept(in_data);
  endtask

  // Directed steps, then randomized traffic
  initial begin
    int n;
    int e0;
    logic acc;
    logic [7:0] bp [5];
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0; clr_err = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_in_ready", in_ready, 1);

`ifndef NPU_SEQ_ACCUM_EN
    // Single op: 0x53 -> input 3, weight 5, core returns 7
    core_lat = 2;
    send_byte(8'h53);
    chk("single_start", npu_start, 1);
    chk("single_input", npu_input, 3);
    chk("single_weight", npu_weight, 5);
    chk("single_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("single_start_pulse", npu_start, 0);
    chk("single_input_hold", npu_input, 3);
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("single_res_valid", res_valid, 1);
    chk("single_res_data", res_data, 7);
    chk("single_elem_idx", elem_idx, 1);
    exp_q.push_back(4'h7);
    drain_all();

    // FIFO full backpressure
    core_lat = 1;
    bp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int i = 0; i < 4; i++) begin
      send_byte(bp[i]);
      wait_idle();
    end
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_res_valid", res_valid, 1);
    in_valid = 1'b1; in_data = bp[4];
    repeat (5) @(posedge clk);
    #1;
    chk("bp_pending_in_ready", in_ready, 0);
    chk("bp_pending_busy", busy, 0);
    res_ready = 1'b1;
    chk("bp_pop_head", res_data, core_fn(bp[0][3:0], bp[0][7:4]));
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_ready_after_pop", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_fifth_issued", npu_start, 1);
    wait_idle();
    for (int i = 1; i < 5; i++) exp_q.push_back(core_fn(bp[i][3:0], bp[i][7:4]));
    drain_all();
    chk("bp_elem_idx", elem_idx, 2);

    // Simultaneous push and pop with two entries held
    send_byte(8'h21); wait_idle();
    send_byte(8'h43); wait_idle();
    core_lat = 3;
    send_byte(8'h65);
    n = 0;
    @(negedge clk);
    while (!npu_done && n < 20) begin @(negedge clk); n++; end
    chk("simul_done_seen", npu_done, 1);
    res_ready = 1'b1;
    chk("simul_head", res_data, core_fn(4'h1, 4'h2));
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("simul_res_valid", res_valid, 1);
    chk("simul_elem_idx", elem_idx, 1);
    exp_q.push_back(core_fn(4'h3, 4'h4));
    exp_q.push_back(core_fn(4'h5, 4'h6));
    drain_all();
`else
    // Accumulate: results 3,4,5,6 saturate to 15 with one push
    core_lat = 1;
    send_byte(8'h04); wait_idle();
    send_byte(8'h05); wait_idle();
    send_byte(8'h06); wait_idle();
    chk("acc_no_push", res_valid, 0);
    chk("acc_elem_3", elem_idx, 3);
    send_byte(8'h07); wait_idle();
    chk("acc_push", res_valid, 1);
    chk("acc_sum", res_data, 15);
    chk("acc_elem_wrap", elem_idx, 0);
    exp_q.push_back(4'hF);
    drain_all();
    send_byte(8'h04); wait_idle();
`endif

    // Timeout: core never answers
    core_lat = 0;
    e0 = int'(elem_idx);
    send_byte(8'h33);
    chk("to_start", npu_start, 1);
    n = 0;
    while (!err_timeout && n < 40) begin @(posedge clk); #1; n++; end
    chk("to_latency", n, TIMEOUT + 2);
    chk("to_busy", busy, 0);
    chk("to_fifo_empty", res_valid, 0);
`ifdef NPU_SEQ_ACCUM_EN
    chk("to_elem_idx", elem_idx, 0);
`else
    chk("to_elem_idx", elem_idx, e0);
`endif
    chk("to_in_ready", in_ready, 1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("to_clr", err_timeout, 0);

    // Timeout with clr_err held: set wins on the timeout cycle
    clr_err = 1'b1;
    send_byte(8'h44);
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    chk("to_set_wins", err_timeout, 1);
    @(posedge clk); #1;
    chk("to_clr_held", err_timeout, 0);
    clr_err = 1'b0;

    // Reset mid-WAIT, late done afterwards is ignored
    core_lat = 5;
    send_byte(8'h21);
    repeat (2) @(posedge clk);
    #1;
    chk("rstw_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_zero("rstw");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rstw_in_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("rstw_no_push", res_valid, 0);
    chk("rstw_idle", busy, 0);
    chk("rstw_elem_idx", elem_idx, 0);

    // Randomized traffic against the job-level reference
    do_reset();
    core_lat = 255;
    exp_q.delete();
    m_elem = 0;
`ifdef NPU_SEQ_ACCUM_EN
    m_acc = 0;
`endif
    for (int i = 0; i < 600; i++) begin
      if (!in_valid && $urandom_range(0, 9) < 6) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      res_ready = ($urandom_range(0, 1) == 1);
      step(acc);
      if (acc) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 80; i++) step(acc);
    res_ready = 1'b0;
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_res_valid", res_valid, 0);
    chk("rnd_busy", busy, 0);
    chk("rnd_elem_idx", elem_idx, m_elem);
    chk("rnd_err", err_timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
